// File: rtl/q2a03_pkg.sv
// q2a03_pkg: shared constants and types for the Q2A03 sprite (OAM) DMA block.
//
// Contents:
//   OAM_DMA_ADDR / OAM_DATA_ADDR  trigger register and OAM data port addresses
//   ST_*                          controller state encodings (state_t)
//   bus_src_e                     bus mux source select (CPU / dummy read / DMA)
//   bus_req_t                     one bus request {addr, wr_data, rdwr}
//   is_oam_trigger()              decodes a CPU write to the trigger register
package q2a03_pkg;

    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_HALT     = 3'd1;
    localparam state_t ST_ALIGN    = 3'd2;
    localparam state_t ST_READ     = 3'd3;
    localparam state_t ST_WRITE    = 3'd4;
    localparam state_t ST_DMC_READ = 3'd5;

    typedef enum logic [1:0] {
        SRC_CPU   = 2'd0,
        SRC_DUMMY = 2'd1,
        SRC_DMA   = 2'd2
    } bus_src_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wr_data;
        logic        rdwr;
    } bus_req_t;

    function automatic logic is_oam_trigger(input logic [15:0] addr, input logic rdwr);
        return (rdwr == 1'b0) && (addr == OAM_DMA_ADDR);
    endfunction

endpackage

// File: rtl/q2a03_bus_mux.sv
// q2a03_bus_mux: combinational source select for the system bus.
//
// Ports:
//   src      in   source select (CPU passthrough, dummy read, DMA request)
//   cpu_req  in   request presented by the core
//   dma_req  in   request generated by the DMA engine
//   bus_req  out  request driven onto the system bus
//
// A dummy read keeps the core's address on the bus but forces a read with
// zero write data, so a halted core can never write anything.
module q2a03_bus_mux
    import q2a03_pkg::*;
(
    input  bus_src_e src,
    input  bus_req_t cpu_req,
    input  bus_req_t dma_req,
    output bus_req_t bus_req
);

    always_comb begin
        bus_req = cpu_req;
        case (src)
            SRC_CPU: bus_req = cpu_req;
            SRC_DMA: bus_req = dma_req;
            default: begin
                bus_req.addr    = cpu_req.addr;
                bus_req.wr_data = 8'h00;
                bus_req.rdwr    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/q2a03_oam_dma.sv
// q2a03_oam_dma: sprite (OAM) DMA controller and bus arbiter for the Q2A03.
//
// While idle the core's bus cycles pass straight through. A core write to
// $4014 halts the core (cpu_ready=0) and copies XFER_LEN bytes from page
// $XX00 to $2004, one get (read) / put (write) cycle pair per byte, then
// returns the bus. All state advances only on G_clock edges with cyc_en=1.
//
// Ports:
//   G_clock, G_reset       clock, synchronous active-high reset
//   cyc_en                 one-clock strobe at each CPU cycle boundary
//   cpu_addr/wr_data/rdwr  core bus request (rdwr 1 = read)
//   cpu_ready              core ready input (0 halts the core)
//   bus_addr/wr_data/rdwr  arbitrated bus request
//   bus_rd_data            bus read data
//   dma_active             high while DMA owns the bus
//   dbg_state              current controller state (ST_* encoding)
//
// Optional build macro Q2A03_DMC_DMA_EN adds a DMC sample fetch channel:
//   dmc_req/dmc_addr in, dmc_ack/dmc_data out. A DMC request steals the next
//   get slot (even mid OAM transfer) and outranks OAM.
//
// Handshake: dmc_req is a level request sampled at cyc_en edges; dmc_ack is
// high for exactly one cyc_en cycle with dmc_data valid, and a request still
// asserted while dmc_ack is high is not serviced again.
module q2a03_oam_dma
    import q2a03_pkg::*;
#(
    parameter int XFER_LEN = 256
)
(
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        cyc_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rdwr,
    output logic        cpu_ready,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wr_data,
    output logic        bus_rdwr,
    input  logic [7:0]  bus_rd_data,
    output logic        dma_active,
`ifdef Q2A03_DMC_DMA_EN
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [7:0] CNT_MASK = 8'(XFER_LEN - 1);

    state_t     state_q, state_d;
    logic       parity_q, parity_d;   // 0 = get cycle, 1 = put cycle
    logic [7:0] page_q, page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] latch_q, latch_d;
    state_t     get_state;            // where the next get slot goes

`ifdef Q2A03_DMC_DMA_EN
    logic       oam_busy_q, oam_busy_d;
    logic       dmc_ack_q, dmc_ack_d;
    logic [7:0] dmc_data_q, dmc_data_d;
    logic       dmc_pend;

    assign dmc_pend  = dmc_req & ~dmc_ack_q;
    // A halt that was not started by an OAM trigger exists only for the DMC.
    assign get_state = (dmc_pend || !oam_busy_q) ? ST_DMC_READ : ST_READ;
    assign dmc_ack   = dmc_ack_q;
    assign dmc_data  = dmc_data_q;
`else
    assign get_state = ST_READ;
`endif

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q;
        page_d   = page_q;
        count_d  = count_q;
        latch_d  = latch_q;
`ifdef Q2A03_DMC_DMA_EN
        oam_busy_d = oam_busy_q;
        dmc_ack_d  = dmc_ack_q;
        dmc_data_d = dmc_data_q;
`endif
        if (cyc_en) begin
            parity_d = ~parity_q;
`ifdef Q2A03_DMC_DMA_EN
            dmc_ack_d = 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (is_oam_trigger(cpu_addr, cpu_rdwr)) begin
                        page_d  = cpu_wr_data;
                        state_d = ST_HALT;
`ifdef Q2A03_DMC_DMA_EN
                        oam_busy_d = 1'b1;
                    end else if (dmc_pend) begin
                        state_d = ST_HALT;
`endif
                    end
                end
                // parity_q is the parity of the HALT cycle itself: if it is
                // a put, the next cycle is already a get.
                ST_HALT:  state_d = parity_q ? get_state : ST_ALIGN;
                ST_ALIGN: state_d = get_state;
                ST_READ: begin
                    latch_d = bus_rd_data;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    count_d = (count_q + 8'd1) & CNT_MASK;
                    if (count_q == CNT_MASK) begin
                        state_d = ST_IDLE;
`ifdef Q2A03_DMC_DMA_EN
                        oam_busy_d = 1'b0;
`endif
                    end else begin
                        state_d = get_state;
                    end
                end
`ifdef Q2A03_DMC_DMA_EN
                ST_DMC_READ: begin
                    dmc_ack_d  = 1'b1;
                    dmc_data_d = bus_rd_data;
                    // The following put slot of an OAM transfer is a dummy read.
                    state_d    = oam_busy_q ? ST_ALIGN : ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge G_clock) begin
        if (G_reset) begin
            state_q  <= ST_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            count_q  <= 8'h00;
            latch_q  <= 8'h00;
`ifdef Q2A03_DMC_DMA_EN
            oam_busy_q <= 1'b0;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            count_q  <= count_d;
            latch_q  <= latch_d;
`ifdef Q2A03_DMC_DMA_EN
            oam_busy_q <= oam_busy_d;
            dmc_ack_q  <= dmc_ack_d;
            dmc_data_q <= dmc_data_d;
`endif
        end
    end

    // Ready/active are derived from the registered state, so both change on
    // the same edge that enters or leaves IDLE.
    assign cpu_ready  = (state_q == ST_IDLE);
    assign dma_active = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

    bus_src_e src;
    bus_req_t cpu_req, dma_req, bus_req;

    assign cpu_req.addr    = cpu_addr;
    assign cpu_req.wr_data = cpu_wr_data;
    assign cpu_req.rdwr    = cpu_rdwr;

    always_comb begin
        src             = SRC_DUMMY;
        dma_req.addr    = {page_q, count_q};
        dma_req.wr_data = 8'h00;
        dma_req.rdwr    = 1'b1;
        case (state_q)
            ST_IDLE: src = SRC_CPU;
            ST_READ: src = SRC_DMA;
            ST_WRITE: begin
                src             = SRC_DMA;
                dma_req.addr    = OAM_DATA_ADDR;
                dma_req.wr_data = latch_q;
                dma_req.rdwr    = 1'b0;
            end
`ifdef Q2A03_DMC_DMA_EN
            ST_DMC_READ: begin
                src          = SRC_DMA;
                dma_req.addr = dmc_addr;
            end
`endif
            default: src = SRC_DUMMY;
        endcase
    end

    q2a03_bus_mux u_bus_mux (
        .src     (src),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .bus_req (bus_req)
    );

    assign bus_addr    = bus_req.addr;
    assign bus_wr_data = bus_req.wr_data;
    assign bus_rdwr    = bus_req.rdwr;

endmodule
